// File: rtl/lu_operand_loader.sv
// Byte-serial operand loader: assembles two 32-bit operands from 8-bit beats
// and presents them as one atomic pair to a downstream 32-bit logical unit.
module lu_operand_loader #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sha_q, sha_d;
  logic [31:0] shb_q, shb_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        out_valid_q, out_valid_d;

  logic        beat_acc;
  logic [1:0]  lane;
  logic [4:0]  lane_lsb;

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign beat_acc  = in_valid && in_ready;
  // For MSB-first streams beat k lands in lane 3-k, which is ~k in two bits.
  assign lane      = LSB_FIRST ? cnt_q : ~cnt_q;
  assign lane_lsb  = {lane, 3'b000};
  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sha_d       = sha_q;
    shb_d       = shb_q;
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;

    if (abort) begin
      state_d     = LOAD_A;
      cnt_d       = 2'd0;
      sha_d       = 32'h0;
      shb_d       = 32'h0;
      a_d         = 32'h0;
      b_d         = 32'h0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (beat_acc) begin
            sha_d[lane_lsb +: 8] = in_data;
            cnt_d                = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (beat_acc) begin
            shb_d[lane_lsb +: 8] = in_data;
            cnt_d                = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              // Publish the whole pair at once, final byte of B included.
              state_d     = HOLD;
              a_d         = sha_q;
              b_d         = shb_d;
              out_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d     = LOAD_A;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = LOAD_A;
          cnt_d       = 2'd0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      cnt_q       <= 2'd0;
      sha_q       <= 32'h0;
      shb_q       <= 32'h0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sha_q       <= sha_d;
      shb_q       <= shb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_lu_operand_loader.sv
// Directed bench: an LSB-first and an MSB-first loader are fed the same pairs
// in matching byte orders and must both produce the same operands.
module tb_lu_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_data_l, in_data_m;
  logic        in_ready_l, in_ready_m;
  logic        out_valid_l, out_valid_m;
  logic [31:0] a_l, b_l, a_m, b_m;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_a, prev_b;

  always #5 clk = ~clk;

  lu_operand_loader #(.LSB_FIRST(1'b1)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .a(a_l), .b(b_l)
  );

  lu_operand_loader #(.LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .a(a_m), .b(b_m)
  );

  typedef struct {
    logic [63:0] beats;  // LSB-first stream, beat 0 in the top byte
    bit          gap;    // idle cycle after every beat but the last
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ov, input logic ir,
                          input logic [31:0] ea, input logic [31:0] eb);
    chk({tag, " out_valid lsb"}, {31'b0, out_valid_l}, {31'b0, ov});
    chk({tag, " out_valid msb"}, {31'b0, out_valid_m}, {31'b0, ov});
    chk({tag, " in_ready lsb"},  {31'b0, in_ready_l},  {31'b0, ir});
    chk({tag, " in_ready msb"},  {31'b0, in_ready_m},  {31'b0, ir});
    chk({tag, " a lsb"}, a_l, ea);
    chk({tag, " b lsb"}, b_l, eb);
    chk({tag, " a msb"}, a_m, ea);
    chk({tag, " b msb"}, b_m, eb);
  endtask

  // Called at a negedge; returns at a negedge after the last beat's edge.
  task automatic send_beats(input logic [63:0] bl, input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      int km;
      km = (k / 4) * 4 + 3 - (k % 4);
      if (k == 4) chk_outs("mid-load", 1'b0, 1'b1, prev_a, prev_b);
      in_valid  = 1'b1;
      in_data_l = bl[63 - 8*k -: 8];
      in_data_m = bl[63 - 8*km -: 8];
      @(posedge clk); @(negedge clk);
      if (gap && k < n - 1) begin
        in_valid  = 1'b0;
        in_data_l = 8'($urandom);
        in_data_m = 8'($urandom);
        @(posedge clk); @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input vec_t v, input bit release_now);
    send_beats(v.beats, 8, v.gap);
    chk_outs("pair hold", 1'b1, 1'b0, v.ea, v.eb);
    prev_a = v.ea;
    prev_b = v.eb;
    if (release_now) begin
      @(posedge clk); @(negedge clk);
      chk_outs("pair released", 1'b0, 1'b1, v.ea, v.eb);
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{64'h47_15_98_CA_B8_EA_67_35, 1'b0, 32'hCA981547, 32'h3567EAB8};
    vecs[1] = '{64'h47_15_98_CA_B8_EA_67_35, 1'b1, 32'hCA981547, 32'h3567EAB8};
    vecs[2] = '{64'h01_02_03_04_05_06_07_08, 1'b0, 32'h04030201, 32'h08070605};
    vecs[3] = '{64'hFF_00_FF_00_00_FF_00_FF, 1'b1, 32'h00FF00FF, 32'hFF00FF00};
    vecs[4] = '{64'h00_00_00_80_01_00_00_00, 1'b0, 32'h80000000, 32'h00000001};

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data_l = 8'h00; in_data_m = 8'h00;
    prev_a = 32'h0; prev_b = 32'h0;
    repeat (2) @(negedge clk);
    chk_outs("in reset", 1'b0, 1'b1, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("after reset", 1'b0, 1'b1, 32'h0, 32'h0);

    for (int i = 0; i < 5; i++) send_pair(vecs[i], 1'b1);

    // Back-pressure; beats offered during HOLD must be ignored.
    out_ready = 1'b0;
    send_pair(vecs[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data_l = 8'hEE; in_data_m = 8'hEE;
      @(posedge clk); @(negedge clk);
      chk_outs("backpressure", 1'b1, 1'b0, vecs[0].ea, vecs[0].eb);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_outs("bp released", 1'b0, 1'b1, vecs[0].ea, vecs[0].eb);
    send_pair(vecs[2], 1'b1);

    // Abort after 6 accepted beats, with a beat presented in the abort cycle.
    send_beats(64'hAA_BB_CC_DD_EE_FF_99_88, 6, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_data_l = 8'h77; in_data_m = 8'h77;
    @(posedge clk); @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk_outs("after abort", 1'b0, 1'b1, 32'h0, 32'h0);
    prev_a = 32'h0; prev_b = 32'h0;
    send_pair(vecs[2], 1'b1);

    // Abort in HOLD beats a simultaneous out_ready.
    out_ready = 1'b0;
    send_pair(vecs[4], 1'b0);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk_outs("abort in hold", 1'b0, 1'b1, 32'h0, 32'h0);
    prev_a = 32'h0; prev_b = 32'h0;
    send_pair(vecs[0], 1'b1);

    // Asynchronous reset pulse between edges while in LOAD_B.
    send_beats(64'h11_22_33_44_55_66_77_88, 5, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_outs("async reset", 1'b0, 1'b1, 32'h0, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    prev_a = 32'h0; prev_b = 32'h0;
    send_pair(vecs[3], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
